conv_layer_scheduler: RTL and testbench
=======================================

# conv_layer_scheduler

Per-layer sequencer for the convolution engine: on a start command it drives the phases weight-load → bias-load → compute → pipeline-drain → done, producing the 3-bit `current_state` and one-cycle `state_rst` that the conv unit, weight memory and bias memory consume. It issues the DDR weight-read request, counts weight beats, waits for bias readiness, dispatches output tiles one at a time, and flushes the MAC pipeline before reporting layer completion. It replaces the free-running state machine in the top level.

## Interface
- `WT_BEAT_W`, 10: width of weight beat count (256-bit DDR beats).
- `TILE_W`, 16: width of tile count.
- `DRAIN_CYCLES`, 6: cycles waited after last `tile_done` (MAC pipeline plus adder tree depth); must be ≥1.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin layer; sampled only in IDLE.
- `cfg_wt_beats` in WT_BEAT_W: weight beats for this layer; latched on accepted `start`.
- `cfg_tile_num` in TILE_W: output tiles for this layer; latched on accepted `start`.
- `ddr_rd_req` out 1: weight read request.
- `ddr_rd_len` out WT_BEAT_W: latched `cfg_wt_beats`; stable while `ddr_rd_req`=1.
- `ddr_rd_ack` in 1: request accepted.
- `ddr_valid` in 1: one weight beat delivered (mirrors `DDR_valid_in`).
- `bias_ready` in 1: bias memory loaded and valid.
- `tile_start` out 1: one-cycle pulse, dispatch next tile.
- `tile_done` in 1: one-cycle pulse, current tile finished.
- `current_state` out 3: phase encoding (see Operation).
- `state_rst` out 1: one-cycle pulse in first cycle of every new state.
- `busy` out 1: high in any state except IDLE.
- `layer_done` out 1: one-cycle pulse, high exactly during DONE.
- `err` out 1: sticky protocol error; cleared only by `rst`.

## Operation
- States/encoding: IDLE=0, WLOAD=1, BLOAD=2, COMPUTE=3, DRAIN=4, DONE=5; 6,7 unreachable, decode to IDLE.
- IDLE: on `start`, latch cfg, go WLOAD (or BLOAD if `cfg_wt_beats`=0). `start` outside IDLE ignored, no error.
- WLOAD: `ddr_rd_req`=1 from entry until cycle `ddr_rd_ack`=1 (inclusive), then 0. Beat counter loads `cfg_wt_beats`, decrements on `ddr_valid`; the cycle it decrements 1→0, next state BLOAD. Beats accepted before ack too.
- BLOAD: go COMPUTE in cycle after `bias_ready`=1 sampled (or DRAIN if `cfg_tile_num`=0).
- COMPUTE: `tile_start` pulses in first cycle of COMPUTE and in cycle after each `tile_done` while tiles remain; at most one tile outstanding. `tile_done` for last tile → DRAIN.
- DRAIN: count DRAIN_CYCLES cycles, then DONE. DONE lasts one cycle → IDLE.
- `err` set by: `ddr_valid` outside WLOAD; `tile_done` outside COMPUTE or with no tile outstanding; `ddr_valid` after counter reached 0.
- Counters are unsigned, no wrap: counts of 2^W−1 supported; decrement from 0 never occurs.

## Timing
- Reset values: `current_state`=0, `state_rst`=0, `ddr_rd_req`=0, `ddr_rd_len`=0, `tile_start`=0, `busy`=0, `layer_done`=0, `err`=0; all counters 0.
- All outputs registered. `start` at cycle t → `current_state`=1, `state_rst`=1, `ddr_rd_req`=1 at t+1.
- Last beat at t → `current_state`=2 at t+1. `bias_ready` at t → state 3 and `tile_start` at t+1.
- `tile_done` at t (not last) → `tile_start` at t+1. Last `tile_done` at t → state 4 at t+1, state 5 at t+1+DRAIN_CYCLES, IDLE one cycle later.
- `rst` mid-layer: next cycle all outputs at reset values; in-flight DDR request abandoned.
- Simultaneous `ddr_rd_ack` and final `ddr_valid`: both honoured, req drops and state advances together.

## Structure
- Package `cnn_sched_pkg`: state encoding constants (3-bit), default widths, DRAIN_CYCLES default.
- One sub-module: `sched_down_counter` (load, decrement enable, zero flag, parameterised width), instanced for beats, tiles, drain.

## Test plan
- Nominal: cfg_wt_beats=4, cfg_tile_num=3, DRAIN_CYCLES=6, ack 2 cycles after req, bias_ready immediate → states 1,2,3,4,5,0 with `state_rst` per transition, 3 `tile_start`s, `layer_done` once, `err`=0.
- Zero counts: cfg_wt_beats=0, cfg_tile_num=0 → IDLE→BLOAD→DRAIN→DONE→IDLE, no `ddr_rd_req`, no `tile_start`.
- Max beats: cfg_wt_beats=1023 with `ddr_valid` gapped randomly → BLOAD exactly after 1023rd beat; extra beat afterwards sets `err`.
- Protocol errors: `tile_done` in IDLE and `ddr_valid` in COMPUTE → `err`=1 and stays 1 until `rst`; state sequence unaffected.
- Reset mid-COMPUTE (tile 2 of 5 outstanding) → next cycle all outputs 0; new `start` runs full layer correctly.
- `start` held high through whole layer → exactly two layers run back-to-back, second starting the cycle after DONE.

Source files
------------

// File: rtl/cnn_sched_pkg.sv
// Shared encodings and default sizing for the convolution layer scheduler.
package cnn_sched_pkg;

  localparam int unsigned STATE_W          = 3;
  localparam int unsigned WT_BEAT_W_DEF    = 10;
  localparam int unsigned TILE_W_DEF       = 16;
  localparam int unsigned DRAIN_CYCLES_DEF = 6;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_WLOAD   = 3'd1;
  localparam logic [STATE_W-1:0] ST_BLOAD   = 3'd2;
  localparam logic [STATE_W-1:0] ST_COMPUTE = 3'd3;
  localparam logic [STATE_W-1:0] ST_DRAIN   = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE    = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = ST_IDLE,
    S_WLOAD   = ST_WLOAD,
    S_BLOAD   = ST_BLOAD,
    S_COMPUTE = ST_COMPUTE,
    S_DRAIN   = ST_DRAIN,
    S_DONE    = ST_DONE
  } sched_state_t;

  // Bits needed to hold the value n (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sched_down_counter.sv
// Loadable down-counter that saturates at zero; reports zero and one for phase exits.
module sched_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c,
  output logic         last_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);
  assign last_c = (count == W'(1));

endmodule

// File: rtl/conv_layer_scheduler.sv
// Per-layer phase sequencer: weight load, bias load, tile dispatch, pipeline drain, done.
module conv_layer_scheduler
  import cnn_sched_pkg::*;
#(
  parameter int unsigned WT_BEAT_W    = WT_BEAT_W_DEF,
  parameter int unsigned TILE_W       = TILE_W_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WT_BEAT_W-1:0] cfg_wt_beats,
  input  logic [TILE_W-1:0]    cfg_tile_num,
  output logic                 ddr_rd_req,
  output logic [WT_BEAT_W-1:0] ddr_rd_len,
  input  logic                 ddr_rd_ack,
  input  logic                 ddr_valid,
  input  logic                 bias_ready,
  output logic                 tile_start,
  input  logic                 tile_done,
  output logic [STATE_W-1:0]   current_state,
  output logic                 state_rst,
  output logic                 busy,
  output logic                 layer_done,
  output logic                 err
);

  localparam int unsigned DRAIN_W = cnt_width(DRAIN_CYCLES);

  sched_state_t state;
  sched_state_t state_nxt_c;
  logic         tile_out;
  logic         start_acc_c, beat_dec_c, tile_fire_c, drain_dec_c;
  logic         drain_load_c, tile_issue_c, err_c;
  logic         beat_zero_c, beat_last_c;
  logic         tile_zero_c, tile_last_c;
  logic         drain_zero_c, drain_last_c;

  // Next-state decode and counter controls.
  always_comb begin
    start_acc_c = (state == S_IDLE) && start;
    beat_dec_c  = (state == S_WLOAD) && ddr_valid && !beat_zero_c;
    tile_fire_c = (state == S_COMPUTE) && tile_done && tile_out;
    drain_dec_c = (state == S_DRAIN) && !drain_zero_c;
    err_c       = (ddr_valid && ((state != S_WLOAD) || beat_zero_c)) ||
                  (tile_done && !tile_fire_c);

    state_nxt_c = state;
    case (state)
      S_IDLE:    if (start) state_nxt_c = (cfg_wt_beats == '0) ? S_BLOAD : S_WLOAD;
      S_WLOAD:   if (beat_dec_c && beat_last_c) state_nxt_c = S_BLOAD;
      S_BLOAD:   if (bias_ready) state_nxt_c = tile_zero_c ? S_DRAIN : S_COMPUTE;
      S_COMPUTE: if (tile_fire_c && tile_last_c) state_nxt_c = S_DRAIN;
      S_DRAIN:   if (drain_last_c) state_nxt_c = S_DONE;
      S_DONE:    state_nxt_c = S_IDLE;
      default:   state_nxt_c = S_IDLE;
    endcase

    drain_load_c = (state_nxt_c == S_DRAIN) && (state != S_DRAIN);
    // First tile on COMPUTE entry, then one per completion while tiles remain.
    tile_issue_c = ((state == S_BLOAD) && (state_nxt_c == S_COMPUTE)) ||
                   (tile_fire_c && !tile_last_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      state_rst  <= 1'b0;
      busy       <= 1'b0;
      layer_done <= 1'b0;
      tile_start <= 1'b0;
      tile_out   <= 1'b0;
      err        <= 1'b0;
      ddr_rd_req <= 1'b0;
      ddr_rd_len <= '0;
    end else begin
      state      <= state_nxt_c;
      state_rst  <= (state_nxt_c != state);
      busy       <= (state_nxt_c != S_IDLE);
      layer_done <= (state_nxt_c == S_DONE);
      tile_start <= tile_issue_c;
      err        <= err | err_c;

      if (tile_issue_c) begin
        tile_out <= 1'b1;
      end else if (tile_fire_c) begin
        tile_out <= 1'b0;
      end

      // Request held from WLOAD entry through the ack cycle; dropped if the phase ends first.
      if (start_acc_c) begin
        ddr_rd_len <= cfg_wt_beats;
        ddr_rd_req <= (cfg_wt_beats != '0);
      end else if ((state == S_WLOAD) && (ddr_rd_ack || (state_nxt_c != S_WLOAD))) begin
        ddr_rd_req <= 1'b0;
      end
    end
  end

  assign current_state = state;

  sched_down_counter #(.W(WT_BEAT_W)) u_beat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (start_acc_c),
    .load_val (cfg_wt_beats),
    .dec      (beat_dec_c),
    .zero_c   (beat_zero_c),
    .last_c   (beat_last_c)
  );

  sched_down_counter #(.W(TILE_W)) u_tile_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (start_acc_c),
    .load_val (cfg_tile_num),
    .dec      (tile_fire_c),
    .zero_c   (tile_zero_c),
    .last_c   (tile_last_c)
  );

  sched_down_counter #(.W(DRAIN_W)) u_drain_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (drain_load_c),
    .load_val (DRAIN_W'(DRAIN_CYCLES)),
    .dec      (drain_dec_c),
    .zero_c   (drain_zero_c),
    .last_c   (drain_last_c)
  );

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Self-checking bench: table of layer configs, expected state/tile events scoreboarded by cycle.
module tb_conv_layer_scheduler;

  localparam int unsigned WB_W  = 10;
  localparam int unsigned T_W   = 16;
  localparam int unsigned DRAIN = 6;
  localparam int K_STATE = 0;
  localparam int K_TILE  = 1;

  logic            clk;
  logic            rst;
  logic            start;
  logic [WB_W-1:0] cfg_wt_beats;
  logic [T_W-1:0]  cfg_tile_num;
  logic            ddr_rd_req;
  logic [WB_W-1:0] ddr_rd_len;
  logic            ddr_rd_ack;
  logic            ddr_valid;
  logic            bias_ready;
  logic            tile_start;
  logic            tile_done;
  logic [2:0]      current_state;
  logic            state_rst;
  logic            busy;
  logic            layer_done;
  logic            err;

  conv_layer_scheduler #(
    .WT_BEAT_W    (WB_W),
    .TILE_W       (T_W),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_wt_beats  (cfg_wt_beats),
    .cfg_tile_num  (cfg_tile_num),
    .ddr_rd_req    (ddr_rd_req),
    .ddr_rd_len    (ddr_rd_len),
    .ddr_rd_ack    (ddr_rd_ack),
    .ddr_valid     (ddr_valid),
    .bias_ready    (bias_ready),
    .tile_start    (tile_start),
    .tile_done     (tile_done),
    .current_state (current_state),
    .state_rst     (state_rst),
    .busy          (busy),
    .layer_done    (layer_done),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int val;
    int edge_no;
  } ev_t;

  typedef struct {
    int wt, tiles, ack_dly, bias_dly, tile_lat, gap_max, inject, abort_tile, twice;
    int exp_req, exp_ts, exp_st, exp_err;
  } vec_t;

  ev_t  q[$];
  vec_t vecs[12];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   cur_len = 0;
  int   req_cnt, ts_cnt, st_cnt, ld_cnt;
  bit   exp_err = 1'b0;
  bit   err_pend = 1'b0;

  task automatic fail(input string msg);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", msg, cyc);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int kind, input int val, input int e);
    ev_t x;
    x.kind = kind;
    x.val = val;
    x.edge_no = e;
    q.push_back(x);
  endfunction

  task automatic match(input int kind);
    ev_t x;
    if (q.size() == 0 || q[0].kind != kind) begin
      if (kind == K_STATE)
        fail($sformatf("unexpected_state_entry: got state %0d, required none", current_state));
      else
        fail("unexpected_tile_start: got pulse, required none");
    end else begin
      x = q.pop_front();
      if (kind == K_STATE) chk("state_value", current_state, x.val);
      chk(kind == K_STATE ? "state_entry_cycle" : "tile_start_cycle", cyc, x.edge_no);
    end
  endtask

  // Advance one clock and observe outputs 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rst) exp_err = 1'b0;
    else if (err_pend) exp_err = 1'b1;
    err_pend = 1'b0;
    chk("err", err, exp_err);
    if (ddr_rd_req) begin
      req_cnt++;
      chk("rd_len", ddr_rd_len, cur_len);
    end
    if (layer_done) begin
      ld_cnt++;
      chk("layer_done_state", current_state, 5);
    end
    if (state_rst) begin
      st_cnt++;
      match(K_STATE);
    end
    if (tile_start) begin
      ts_cnt++;
      match(K_TILE);
    end
    while (q.size() > 0 && q[0].edge_no <= cyc) begin
      fail($sformatf("missed_event: kind %0d value %0d required at cycle %0d, got none",
                     q[0].kind, q[0].val, q[0].edge_no));
      void'(q.pop_front());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, current_state, 0);
    chk({tag, "_state_rst"}, state_rst, 0);
    chk({tag, "_rd_req"}, ddr_rd_req, 0);
    chk({tag, "_rd_len"}, ddr_rd_len, 0);
    chk({tag, "_tile_start"}, tile_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_layer_done"}, layer_done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    ddr_rd_ack = 1'b0;
    ddr_valid = 1'b0;
    bias_ready = 1'b0;
    tile_done = 1'b0;
    cfg_wt_beats = '0;
    cfg_tile_num = '0;
    step();
    rst = 1'b0;
    q.delete();
    chk_reset_outputs("reset");
  endtask

  task automatic run_layer(input vec_t v, input bit hold);
    int  left, k, e_d, guard;
    bit  aborted;
    req_cnt = 0;
    ts_cnt = 0;
    st_cnt = 0;
    ld_cnt = 0;
    aborted = 1'b0;
    cfg_wt_beats = WB_W'(v.wt);
    cfg_tile_num = T_W'(v.tiles);
    cur_len = v.wt;
    start = 1'b1;
    push(K_STATE, (v.wt == 0) ? 2 : 1, cyc + 1);
    step();
    if (!hold) start = 1'b0;
    chk("busy_after_start", busy, 1);

    // Weight beats, optionally gapped; ack issued ack_dly cycles after request.
    left = v.wt;
    k = 0;
    while (left > 0) begin
      ddr_valid = (v.gap_max == 0) ? 1'b1 : ($urandom_range(v.gap_max, 0) == 0);
      ddr_rd_ack = (k == v.ack_dly);
      if (ddr_valid) begin
        left--;
        if (left == 0) push(K_STATE, 2, cyc + 1);
      end
      step();
      k++;
    end
    ddr_valid = 1'b0;
    ddr_rd_ack = 1'b0;
    chk("rd_req_in_bload", ddr_rd_req, 0);

    for (int j = 0; j <= v.bias_dly; j++) begin
      bias_ready = (j == v.bias_dly);
      ddr_valid = (v.inject == 1) && (j == 0);
      if (ddr_valid) err_pend = 1'b1;
      if (bias_ready) begin
        if (v.tiles == 0) begin
          push(K_STATE, 4, cyc + 1);
        end else begin
          push(K_STATE, 3, cyc + 1);
          push(K_TILE, 1, cyc + 1);
        end
      end
      step();
    end
    bias_ready = 1'b0;
    ddr_valid = 1'b0;
    e_d = cyc;

    for (int i = 0; i < v.tiles && !aborted; i++) begin
      if (i == v.abort_tile) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outputs("abort");
        aborted = 1'b1;
      end else begin
        for (int w = 0; w < v.tile_lat; w++) begin
          ddr_valid = (v.inject == 2) && (i == 0) && (w == 0);
          if (ddr_valid) err_pend = 1'b1;
          step();
        end
        ddr_valid = 1'b0;
        tile_done = 1'b1;
        if (i == v.tiles - 1) push(K_STATE, 4, cyc + 1);
        else push(K_TILE, 1, cyc + 1);
        step();
        tile_done = 1'b0;
        e_d = cyc;
      end
    end

    if (!aborted) begin
      push(K_STATE, 5, e_d + DRAIN);
      push(K_STATE, 0, e_d + DRAIN + 1);
      guard = 0;
      while (q.size() > 0 && guard < DRAIN + 8) begin
        step();
        guard++;
      end
      if (q.size() > 0) begin
        fail($sformatf("drain_timeout: got %0d events pending, required 0", q.size()));
        q.delete();
      end
      chk("layer_done_count", ld_cnt, 1);
      chk("busy_at_end", busy, 0);
    end
    q.delete();
    chk("req_cycles", req_cnt, v.exp_req);
    chk("tile_starts", ts_cnt, v.exp_ts);
    chk("state_entries", st_cnt, v.exp_st);
    chk("err_at_end", err, v.exp_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t pe;
    //          wt  tl ack bia lat gap inj abt two  req ts st err
    vecs[0]  = '{   4, 3, 2, 0, 1, 0, 0, -1, 0,   3, 3, 6, 0};
    vecs[1]  = '{   0, 0, 0, 0, 1, 0, 0, -1, 0,   0, 0, 4, 0};
    vecs[2]  = '{   1, 1, 0, 3, 0, 0, 0, -1, 0,   1, 1, 6, 0};
    vecs[3]  = '{   3, 2, 2, 1, 4, 0, 0, -1, 0,   3, 2, 6, 0};
    vecs[4]  = '{   0, 2, 0, 2, 2, 0, 0, -1, 0,   0, 2, 5, 0};
    vecs[5]  = '{   5, 0, 1, 0, 1, 0, 0, -1, 0,   2, 0, 5, 0};
    vecs[6]  = '{   8, 4, 1, 1, 1, 2, 0, -1, 0,   2, 4, 6, 0};
    vecs[7]  = '{1023, 1, 5, 0, 2, 1, 1, -1, 0,   6, 1, 6, 1};
    vecs[8]  = '{   2, 3, 1, 0, 2, 0, 2, -1, 0,   2, 3, 6, 1};
    vecs[9]  = '{   2, 5, 0, 0, 3, 0, 0,  1, 0,   1, 2, 3, 0};
    vecs[10] = '{   2, 5, 0, 0, 1, 0, 0, -1, 0,   1, 5, 6, 0};
    vecs[11] = '{   2, 1, 0, 0, 1, 0, 0, -1, 1,   1, 1, 6, 0};

    do_reset();
    repeat (2) step();
    chk("idle_stays_idle", current_state, 0);

    for (int n = 0; n < 12; n++) begin
      do_reset();
      run_layer(vecs[n], vecs[n].twice != 0);
      if (vecs[n].twice != 0) begin
        run_layer(vecs[n], 1'b0);
        repeat (4) step();
        chk("no_third_layer", current_state, 0);
      end
    end

    // Stray tile_done in IDLE: error sticks, following layer runs normally.
    do_reset();
    tile_done = 1'b1;
    err_pend = 1'b1;
    step();
    tile_done = 1'b0;
    repeat (3) step();
    pe = vecs[0];
    pe.exp_err = 1;
    run_layer(pe, 1'b0);
    repeat (2) step();
    chk("err_sticky_idle", err, 1);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
